// File: rtl/maxpool_a2.sv
// ---------------------------------------------------------------------------
// maxpool_a2 -- 2x2 / stride-2 signed max pooling over a multi-channel map.
//
// A frame is pulled from the upstream ping-pong memory one word per cycle,
// window by window (channel-major, then output row, then output column).
// Each completed window's maximum is written to the downstream memory two
// cycles after its last read. The frame is then handed to the next stage
// with a start pulse, and the output bank select flips.
//
// Ports
//   clk                  clock
//   reset                asynchronous, active-high reset
//   start_from_previous  1-cycle pulse: upstream frame ready
//   end_to_previous      high while idle (a start will be accepted)
//   ifm_enable_read      input memory read strobe
//   ifm_sel              input channel being read
//   ifm_address_read     row*IFM_SIZE+col within the channel
//   ifm_data_in          read data, valid the cycle after the strobe
//   ofm_enable_write     output memory write strobe
//   ofm_address_write    ch*OFM_SIZE^2 + r*OFM_SIZE + c
//   ofm_data_out         pooled maximum
//   ofm_sel_next         output ping-pong bank select
//   start_to_next        1-cycle pulse: frame handed downstream
//   end_from_next        downstream idle
// ---------------------------------------------------------------------------
module maxpool_a2 #(
    parameter int DATA_WIDTH = 32,
    parameter int IFM_SIZE   = 10,
    parameter int IFM_DEPTH  = 2,
    localparam int OFM_SIZE  = IFM_SIZE / 2,
    localparam int ADDR_IN   = $clog2(IFM_SIZE * IFM_SIZE),
    localparam int ADDR_OUT  = $clog2(IFM_DEPTH * OFM_SIZE * OFM_SIZE),
    localparam int SEL_W     = (IFM_DEPTH > 1) ? $clog2(IFM_DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_from_previous,
    output logic                  end_to_previous,
    output logic                  ifm_enable_read,
    output logic [SEL_W-1:0]      ifm_sel,
    output logic [ADDR_IN-1:0]    ifm_address_read,
    input  logic [DATA_WIDTH-1:0] ifm_data_in,
    output logic                  ofm_enable_write,
    output logic [ADDR_OUT-1:0]   ofm_address_write,
    output logic [DATA_WIDTH-1:0] ofm_data_out,
    output logic                  ofm_sel_next,
    output logic                  start_to_next,
    input  logic                  end_from_next
);

    localparam int CNT_W     = (OFM_SIZE > 1) ? $clog2(OFM_SIZE) : 1;
    localparam int OFM_TOTAL = IFM_DEPTH * OFM_SIZE * OFM_SIZE;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        DRAIN   = 2'd2,
        HANDOFF = 2'd3
    } state_t;

    state_t                        state_r;
    state_t                        state_next_s;
    logic [SEL_W-1:0]              ch_r;
    logic [CNT_W-1:0]              orow_r;
    logic [CNT_W-1:0]              ocol_r;
    logic [1:0]                    win_r;
    logic                          drain_r;
    logic                          ocol_last_s;
    logic                          orow_last_s;
    logic                          ch_last_s;
    logic                          last_read_s;
    logic [CNT_W:0]                row_s;
    logic [CNT_W:0]                col_s;

    // Read-pipeline tags travelling alongside the data returned by memory.
    logic                          rd_valid_r;
    logic                          rd_first_r;
    logic                          rd_last_r;
    logic signed [DATA_WIDTH-1:0]  max_r;
    logic signed [DATA_WIDTH-1:0]  next_max_s;
    logic                          ofm_enable_write_r;
    logic [ADDR_OUT-1:0]           ofm_address_write_r;
    logic [DATA_WIDTH-1:0]         ofm_data_out_r;
    logic                          ofm_sel_next_r;

    assign ocol_last_s = (ocol_r == CNT_W'(OFM_SIZE - 1));
    assign orow_last_s = (orow_r == CNT_W'(OFM_SIZE - 1));
    assign ch_last_s   = (ch_r == SEL_W'(IFM_DEPTH - 1));
    assign last_read_s = (state_r == READ) && (win_r == 2'd3) &&
                         ocol_last_s && orow_last_s && ch_last_s;

    // Window element w sits at (2r + w[1], 2c + w[0]).
    assign row_s = {orow_r, win_r[1]};
    assign col_s = {ocol_r, win_r[0]};
    assign ifm_address_read = ADDR_IN'(32'(row_s) * 32'(IFM_SIZE) + 32'(col_s));
    assign ifm_sel          = ch_r;

    assign ofm_enable_write  = ofm_enable_write_r;
    assign ofm_address_write = ofm_address_write_r;
    assign ofm_data_out      = ofm_data_out_r;
    assign ofm_sel_next      = ofm_sel_next_r;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_from_previous) begin
                    state_next_s = READ;
                end else begin
                    state_next_s = IDLE;
                end
            end
            READ: begin
                if (last_read_s) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = READ;
                end
            end
            DRAIN: begin
                if (drain_r) begin
                    state_next_s = HANDOFF;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            HANDOFF: begin
                if (end_from_next) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = HANDOFF;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        end_to_previous = 1'b0;
        ifm_enable_read = 1'b0;
        start_to_next   = 1'b0;
        case (state_r)
            IDLE:    end_to_previous = 1'b1;
            READ:    ifm_enable_read = 1'b1;
            DRAIN:   ifm_enable_read = 1'b0;
            HANDOFF: start_to_next   = end_from_next;
            default: end_to_previous = 1'b0;
        endcase
    end

    // Window / column / row / channel counters; cleared whenever not reading
    // so every frame starts at channel 0, position 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ch_r   <= '0;
            orow_r <= '0;
            ocol_r <= '0;
            win_r  <= 2'd0;
        end else if (state_r == READ) begin
            win_r <= win_r + 2'd1;
            if (win_r == 2'd3) begin
                ocol_r <= ocol_last_s ? '0 : ocol_r + CNT_W'(1);
                if (ocol_last_s) begin
                    orow_r <= orow_last_s ? '0 : orow_r + CNT_W'(1);
                    if (orow_last_s) begin
                        ch_r <= ch_last_s ? '0 : ch_r + SEL_W'(1);
                    end
                end
            end
        end else begin
            ch_r   <= '0;
            orow_r <= '0;
            ocol_r <= '0;
            win_r  <= 2'd0;
        end
    end

    // Two-cycle drain timer: lets the last window's data return and be written.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drain_r <= 1'b0;
        end else if (state_r == DRAIN) begin
            drain_r <= ~drain_r;
        end else begin
            drain_r <= 1'b0;
        end
    end

    // Tag each read so the returning word knows its window position.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid_r <= 1'b0;
            rd_first_r <= 1'b0;
            rd_last_r  <= 1'b0;
        end else begin
            rd_valid_r <= ifm_enable_read;
            rd_first_r <= (win_r == 2'd0);
            rd_last_r  <= (win_r == 2'd3);
        end
    end

    // Running signed maximum; ties keep the current value.
    always_comb begin
        if (rd_first_r) begin
            next_max_s = $signed(ifm_data_in);
        end else if ($signed(ifm_data_in) > max_r) begin
            next_max_s = $signed(ifm_data_in);
        end else begin
            next_max_s = max_r;
        end
    end

    // Max accumulator and output write stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            max_r              <= '0;
            ofm_enable_write_r <= 1'b0;
            ofm_data_out_r     <= '0;
        end else begin
            if (rd_valid_r) begin
                max_r <= next_max_s;
            end
            ofm_enable_write_r <= rd_valid_r && rd_last_r;
            if (rd_valid_r && rd_last_r) begin
                ofm_data_out_r <= next_max_s;
            end
        end
    end

    // Output address advances after each write and wraps at the frame end.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ofm_address_write_r <= '0;
        end else if (ofm_enable_write_r) begin
            if (ofm_address_write_r == ADDR_OUT'(OFM_TOTAL - 1)) begin
                ofm_address_write_r <= '0;
            end else begin
                ofm_address_write_r <= ofm_address_write_r + ADDR_OUT'(1);
            end
        end
    end

    // Output bank flips when the frame is accepted downstream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ofm_sel_next_r <= 1'b0;
        end else if ((state_r == HANDOFF) && end_from_next) begin
            ofm_sel_next_r <= ~ofm_sel_next_r;
        end
    end

endmodule

// File: tb/tb_maxpool_a2.sv
module tb_maxpool_a2;
    localparam int S = 10;
    localparam int D = 2;
    localparam int O = 5;
    localparam int NRD = D * S * S;
    localparam int NWR = D * O * O;

    typedef struct { int cyc; int sel; int addr; } rd_t;
    typedef struct { int cyc; int addr; int data; } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_from_previous = 1'b0;
    logic        end_to_previous;
    logic        ifm_enable_read;
    logic [0:0]  ifm_sel;
    logic [6:0]  ifm_address_read;
    logic [31:0] ifm_data_in = 32'd0;
    logic        ofm_enable_write;
    logic [5:0]  ofm_address_write;
    logic [31:0] ofm_data_out;
    logic        ofm_sel_next;
    logic        start_to_next;
    logic        end_from_next = 1'b1;

    int mem [0:D-1][0:S*S-1];
    rd_t rd_q[$];
    rd_t exp_rd[$];
    wr_t wr_q[$];
    wr_t exp_wr[$];
    int  stn_q[$];
    int  busy_n;
    int  cyc = 0;
    int  base = 0;
    bit  log_en = 1'b0;
    int  n_asrt = 0;
    int  n_fail = 0;

    maxpool_a2 dut (
        .clk(clk), .reset(reset),
        .start_from_previous(start_from_previous), .end_to_previous(end_to_previous),
        .ifm_enable_read(ifm_enable_read), .ifm_sel(ifm_sel),
        .ifm_address_read(ifm_address_read), .ifm_data_in(ifm_data_in),
        .ofm_enable_write(ofm_enable_write), .ofm_address_write(ofm_address_write),
        .ofm_data_out(ofm_data_out), .ofm_sel_next(ofm_sel_next),
        .start_to_next(start_to_next), .end_from_next(end_from_next)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Input memory: data one cycle after the read strobe.
    always @(posedge clk) begin
        if (ifm_enable_read) ifm_data_in <= mem[ifm_sel][ifm_address_read];
    end

    // Activity log, sampled shortly after the falling edge.
    always @(negedge clk) begin
        #2;
        if (log_en) begin
            if (ifm_enable_read)
                rd_q.push_back('{cyc - base, int'(ifm_sel), int'(ifm_address_read)});
            if (ofm_enable_write)
                wr_q.push_back('{cyc - base, int'(ofm_address_write), int'(ofm_data_out)});
            if (start_to_next) stn_q.push_back(cyc - base);
            if (!end_to_previous) busy_n++;
        end
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: every read in scan order one per cycle from cycle 1; window k's
    // maximum written at cycle 4k+6 to address k.
    task automatic build_model();
        int k;
        int m;
        int v;
        exp_rd.delete();
        exp_wr.delete();
        k = 0;
        for (int ch = 0; ch < D; ch++)
            for (int r = 0; r < O; r++)
                for (int c = 0; c < O; c++) begin
                    for (int w = 0; w < 4; w++) begin
                        v = mem[ch][(2*r + w/2)*S + 2*c + w%2];
                        exp_rd.push_back('{4*k + w + 1, ch, (2*r + w/2)*S + 2*c + w%2});
                        if (w == 0 || v > m) m = v;
                    end
                    exp_wr.push_back('{4*k + 6, k, m});
                    k++;
                end
    endtask

    task automatic clear_log();
        rd_q.delete();
        wr_q.delete();
        stn_q.delete();
        busy_n = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start_from_previous = 1'b1;
        base = cyc;
        log_en = 1'b1;
        @(negedge clk);
        start_from_previous = 1'b0;
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_etp"}, end_to_previous, 1);
        chk({nm, "_rd"}, ifm_enable_read, 0);
        chk({nm, "_wr"}, ofm_enable_write, 0);
        chk({nm, "_stn"}, start_to_next, 0);
        chk({nm, "_sel"}, ifm_sel, 0);
        chk({nm, "_waddr"}, ofm_address_write, 0);
        chk({nm, "_wdata"}, ofm_data_out, 0);
        chk({nm, "_selnext"}, ofm_sel_next, 0);
    endtask

    task automatic run_frame(input bit bp, input bit extra, input int sel_after, input string nm);
        int t;
        build_model();
        clear_log();
        end_from_next = !bp;
        pulse_start();
        if (extra) begin
            repeat (49) @(negedge clk);
            start_from_previous = 1'b1;
            @(negedge clk);
            start_from_previous = 1'b0;
        end
        t = 0;
        while (wr_q.size() < NWR && t < 500) begin @(negedge clk); t++; end
        chk({nm, "_wr_timeout"}, t < 500, 1);
        if (bp) begin
            repeat (2) @(negedge clk);
            for (int i = 0; i < 20; i++) begin
                chk($sformatf("%s_bp_stn%0d", nm, i), start_to_next, 0);
                chk($sformatf("%s_bp_strobe%0d", nm, i), ifm_enable_read | ofm_enable_write, 0);
                chk($sformatf("%s_bp_busy%0d", nm, i), end_to_previous, 0);
                @(negedge clk);
            end
            chk({nm, "_bp_sel_hold"}, ofm_sel_next, !sel_after);
            end_from_next = 1'b1;
        end
        t = 0;
        while (stn_q.size() < 1 && t < 100) begin @(negedge clk); t++; end
        chk({nm, "_stn_timeout"}, t < 100, 1);
        repeat (3) @(negedge clk);
        log_en = 1'b0;
        chk({nm, "_stn_pulses"}, stn_q.size(), 1);
        if (stn_q.size() > 0) chk({nm, "_busy_until_idle"}, busy_n, stn_q[0]);
        if (!bp && stn_q.size() > 0) chk({nm, "_stn_cycle"}, stn_q[0], 203);
        chk({nm, "_sel_next"}, ofm_sel_next, sel_after);
        chk({nm, "_idle"}, end_to_previous, 1);
        chk({nm, "_n_reads"}, rd_q.size(), NRD);
        chk({nm, "_n_writes"}, wr_q.size(), NWR);
        for (int i = 0; i < rd_q.size() && i < NRD; i++) begin
            chk($sformatf("%s_rd%0d_cyc", nm, i), rd_q[i].cyc, exp_rd[i].cyc);
            chk($sformatf("%s_rd%0d_sel", nm, i), rd_q[i].sel, exp_rd[i].sel);
            chk($sformatf("%s_rd%0d_addr", nm, i), rd_q[i].addr, exp_rd[i].addr);
        end
        for (int i = 0; i < wr_q.size() && i < NWR; i++) begin
            chk($sformatf("%s_wr%0d_cyc", nm, i), wr_q[i].cyc, exp_wr[i].cyc);
            chk($sformatf("%s_wr%0d_addr", nm, i), wr_q[i].addr, exp_wr[i].addr);
            chk($sformatf("%s_wr%0d_data", nm, i), wr_q[i].data, exp_wr[i].data);
        end
    endtask

    task automatic fill_random();
        for (int ch = 0; ch < D; ch++)
            for (int a = 0; a < S*S; a++)
                mem[ch][a] = int'($urandom);
    endtask

    initial begin
        // Reset state.
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("post_reset_idle");

        // Nominal frame with downstream backpressure.
        for (int ch = 0; ch < D; ch++)
            for (int a = 0; a < S*S; a++)
                mem[ch][a] = ch*1000 + a;
        run_frame(1'b1, 1'b0, 1, "nominal");
        if (wr_q.size() == NWR) begin
            chk("nominal_first_cyc", wr_q[0].cyc, 6);
            chk("nominal_first_addr", wr_q[0].addr, 0);
            chk("nominal_first_data", wr_q[0].data, 11);
            chk("nominal_a24_data", wr_q[24].data, 99);
            chk("nominal_a25_data", wr_q[25].data, 1011);
            chk("nominal_last_cyc", wr_q[49].cyc, 202);
            chk("nominal_last_addr", wr_q[49].addr, 49);
            chk("nominal_last_data", wr_q[49].data, 1099);
        end

        // Signed windows, random elsewhere, start pulse while busy.
        fill_random();
        mem[0][0] = -5;  mem[0][1] = -3;  mem[0][10] = -9; mem[0][11] = -4;
        mem[0][2] = -7;  mem[0][3] = -7;  mem[0][12] = -7; mem[0][13] = -7;
        run_frame(1'b0, 1'b1, 0, "signed");
        if (wr_q.size() == NWR) begin
            chk("signed_mixed_max", wr_q[0].data, -3);
            chk("signed_equal_max", wr_q[1].data, -7);
            chk("frame2_addr_restart", wr_q[0].addr, 0);
        end

        fill_random();
        run_frame(1'b0, 1'b0, 1, "rand");

        // Reset in the middle of a frame.
        fill_random();
        clear_log();
        pulse_start();
        repeat (99) @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        log_en = 1'b0;
        chk("midreset_writes_stop", wr_q.size(), 24);
        chk("midreset_reads_stop", rd_q.size(), 99);
        check_reset_outputs("midreset_idle");

        fill_random();
        run_frame(1'b0, 1'b0, 1, "after_reset");
        if (rd_q.size() > 0) begin
            chk("after_reset_first_sel", rd_q[0].sel, 0);
            chk("after_reset_first_raddr", rd_q[0].addr, 0);
        end
        if (wr_q.size() > 0) chk("after_reset_first_waddr", wr_q[0].addr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule

// File: doc/maxpool_a2.md
MAXPOOL_A2 -- requirements
Module: maxpool_a2

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning signed feature-map word width.
REQ-002 The block SHALL have parameter IFM_SIZE, default 10, meaning input map side length; it must be even.
REQ-003 The block SHALL have parameter IFM_DEPTH, default 2, meaning number of input channels.
REQ-004 The block SHALL have derived parameters OFM_SIZE=IFM_SIZE/2, ADDR_IN=$clog2(IFM_SIZE*IFM_SIZE), ADDR_OUT=$clog2(IFM_DEPTH*OFM_SIZE*OFM_SIZE) and SEL_W=max(1,$clog2(IFM_DEPTH)).
REQ-005 The block SHALL have port clk, input, 1 bit: clock.
REQ-006 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-007 The block SHALL have port start_from_previous, input, 1 bit: one-cycle pulse meaning the upstream frame is ready.
REQ-008 The block SHALL have port end_to_previous, output, 1 bit: high when the block can accept a start.
REQ-009 The block SHALL have port ifm_enable_read, output, 1 bit: input memory read strobe.
REQ-010 The block SHALL have port ifm_sel, output, SEL_W bits: current input channel.
REQ-011 The block SHALL have port ifm_address_read, output, ADDR_IN bits: row*IFM_SIZE+col within the channel.
REQ-012 The block SHALL have port ifm_data_in, input, DATA_WIDTH bits: read data, valid one cycle after the strobe.
REQ-013 The block SHALL have port ofm_enable_write, output, 1 bit: output memory write strobe.
REQ-014 The block SHALL have port ofm_address_write, output, ADDR_OUT bits: ch*OFM_SIZE^2 + r*OFM_SIZE + c.
REQ-015 The block SHALL have port ofm_data_out, output, DATA_WIDTH bits: pooled maximum.
REQ-016 The block SHALL have port ofm_sel_next, output, 1 bit: output ping-pong bank select.
REQ-017 The block SHALL have port start_to_next, output, 1 bit: one-cycle pulse handing a frame downstream.
REQ-018 The block SHALL have port end_from_next, input, 1 bit: high when downstream is idle.

Function
REQ-019 The block SHALL implement states IDLE, READ, DRAIN and HANDOFF.
REQ-020 In IDLE with start_from_previous=1, the block SHALL enter READ at the next edge; a start in any other state SHALL be ignored.
REQ-021 In READ, the block SHALL assert ifm_enable_read every cycle, issuing one read per cycle.
REQ-022 The READ order SHALL be channel-major, then output row r and output column c, and within each window (2r,2c), (2r,2c+1), (2r+1,2c), (2r+1,2c+1).
REQ-023 The block SHALL issue IFM_DEPTH*IFM_SIZE^2 reads per frame, which is 200 at the default parameters.
REQ-024 After issuing the last read, the block SHALL enter DRAIN for exactly 2 cycles and then enter HANDOFF.
REQ-025 The max register SHALL load window element 0 and then take the signed maximum with elements 1-3; on equal values it SHALL keep the current value.
REQ-026 If the 4th read of a window is issued in cycle t, the block SHALL assert ofm_enable_write for exactly cycle t+2, with the window's max and address.
REQ-027 ofm_address_write SHALL increment by 1 per write, covering 0 to IFM_DEPTH*OFM_SIZE^2-1, and SHALL wrap to 0 for the next frame.
REQ-028 In HANDOFF with end_from_next=1, the block SHALL assert start_to_next combinationally in that cycle, toggle ofm_sel_next at the edge, and go to IDLE.
REQ-029 In HANDOFF with end_from_next=0, the block SHALL hold in HANDOFF with start_to_next=0 and no memory strobes.
REQ-030 end_to_previous SHALL be 1 in IDLE only, and 0 in READ, DRAIN and HANDOFF.
REQ-031 All column, row, window and channel counters SHALL wrap to 0 at their terminal counts, and SHALL be 0 on entry to READ.
REQ-032 ifm_sel SHALL advance at the edge after the channel's last read.
REQ-033 ifm_enable_read and ofm_enable_write SHALL never be high outside READ/DRAIN.

Reset
REQ-034 On reset, the block SHALL go to state IDLE.
REQ-035 On reset, all counters, ifm_sel, ofm_address_write, ofm_data_out and ofm_sel_next SHALL be 0.
REQ-036 On reset, ifm_enable_read, ofm_enable_write and start_to_next SHALL be 0, and end_to_previous SHALL be 1.
REQ-037 Reset asserted mid-frame SHALL abort the frame immediately, with no further writes.
REQ-038 After a mid-frame reset, the next start SHALL restart from channel 0 at address 0.

Verification
REQ-039 The bench SHALL cover the nominal frame: memory data ch*1000+addr, start pulse at cycle 0 -> reads in cycles 1-200; first write in cycle 6 at address 0 with data 11; write at address 24 with data 99; write at address 25 with data 1011; last write in cycle 202 at address 49 with data 1099.
REQ-040 The bench SHALL cover signed data: window values {-5,-3,-9,-4} -> written max -3; an all-equal window of -7 -> written -7.
REQ-041 The bench SHALL cover backpressure: end_from_next=0 for 20 cycles after DRAIN -> start_to_next stays 0 and the block stays in HANDOFF; raising end_from_next -> a one-cycle start_to_next pulse and ofm_sel_next flips 0->1.
REQ-042 The bench SHALL cover start while busy: an extra start_from_previous pulse at cycle 50 -> no effect; the frame still ends after 50 writes and end_to_previous=0 until IDLE.
REQ-043 The bench SHALL cover reset mid-frame: reset at cycle 100 -> all outputs return to reset values; a new start -> first read at channel 0, address 0, and first write at address 0.
REQ-044 The bench SHALL cover back-to-back frames: two frames -> ofm_sel_next sequence 0,1,0 and ofm_address_write restarting at 0 in frame 2.
